// File: rtl/regs_file_mp_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// Optional read bypass of a committing core write is enabled by REGS_FILE_BYPASS_EN.
package regs_file_mp_pkg;

  localparam int unsigned CPU_WIDTH      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned REG_DATA_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ACK   = 2'd2
  } rf_state_e;

  // Entry exists and is not the hardwired zero register.
  function automatic logic entry_live(input int unsigned addr,
                                      input int unsigned depth,
                                      input bit          zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regs_file_mp_if.sv
// Debug (JTAG) access handshake for the register file.
interface regs_file_mp_if
  import regs_file_mp_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_WIDTH,
  parameter int unsigned DATA_W = CPU_WIDTH
);
  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_ack_o;
  logic [DATA_W-1:0] dbg_rdata_o;

  modport master (output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
                  input  dbg_ack_o, dbg_rdata_o);
  modport slave  (input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
                  output dbg_ack_o, dbg_rdata_o);
endinterface

// File: rtl/regs_file_mp_ctrl.sv
// Register file control: clear sweep, debug accept/ack FSM and the single storage write mux.
module regs_file_mp_ctrl
  import regs_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_WIDTH,
  parameter int unsigned ADDR_W   = REG_ADDR_WIDTH,
  parameter int unsigned DEPTH    = REG_DATA_DEPTH,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_req_i,
  input  logic [DATA_W-1:0] dbg_ent_i,
  output logic              busy_o,
  output logic              st_we_o_c,
  output logic [ADDR_W-1:0] st_waddr_o_c,
  output logic [DATA_W-1:0] st_wdata_o_c,
  regs_file_mp_if.slave     dbg
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              core_wr;
  logic              dbg_wr_ok;

  assign core_wr   = wr_en_i && !busy_q && entry_live(32'(wr_addr_i), DEPTH, ZERO_REG != 0);
  assign dbg_wr_ok = entry_live(32'(dbg.dbg_addr_i), DEPTH, ZERO_REG != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    ack_d        = 1'b0;
    rdata_d      = rdata_q;
    st_we_o_c    = core_wr;
    st_waddr_o_c = wr_addr_i;
    st_wdata_o_c = wr_data_i;
    unique case (state_q)
      ST_CLEAR: begin
        st_we_o_c    = 1'b1;
        st_waddr_o_c = clr_idx_q;
        st_wdata_o_c = '0;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
        else                                 clr_idx_d = clr_idx_q + ADDR_W'(1);
      end
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else if (dbg.dbg_req_i && !(dbg.dbg_we_i && core_wr)) begin
          // Core write wins the single write port; a debug write simply stalls.
          state_d = ST_ACK;
          ack_d   = 1'b1;
          rdata_d = dbg_ent_i;
          if (dbg.dbg_we_i && dbg_wr_ok) begin
            st_we_o_c    = 1'b1;
            st_waddr_o_c = dbg.dbg_addr_i;
            st_wdata_o_c = dbg.dbg_wdata_i;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  assign busy_o          = busy_q;
  assign dbg.dbg_ack_o   = ack_q;
  assign dbg.dbg_rdata_o = rdata_q;

endmodule

// File: rtl/regs_file_mp.sv
// Multi-port integer register file with clear sweep and debug port (ID stage, written from WB).
// Define REGS_FILE_BYPASS_EN to forward a committing core write to matching read ports.
module regs_file_mp
  import regs_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_WIDTH,
  parameter int unsigned ADDR_W   = REG_ADDR_WIDTH,
  parameter int unsigned DEPTH    = REG_DATA_DEPTH,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  input  logic                  clr_req_i,
  output logic                  busy_o,
  regs_file_mp_if.slave         dbg
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              st_we;
  logic [ADDR_W-1:0] st_waddr;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] dbg_ent;

  regs_file_mp_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .clr_req_i   (clr_req_i),
    .dbg_ent_i   (dbg_ent),
    .busy_o      (busy_o),
    .st_we_o_c   (st_we),
    .st_waddr_o_c(st_waddr),
    .st_wdata_o_c(st_wdata),
    .dbg         (dbg)
  );

  // Storage is deliberately not reset; the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (st_we) mem_q[st_waddr] <= st_wdata;
  end

  assign dbg_ent = entry_live(32'(dbg.dbg_addr_i), DEPTH, ZERO_REG != 0) ?
                   mem_q[dbg.dbg_addr_i] : '0;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              live;
    assign ra   = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign live = !busy_o && entry_live(32'(ra), DEPTH, ZERO_REG != 0);
`ifdef REGS_FILE_BYPASS_EN
    // A live read address matching wr_addr_i implies the core write commits.
    assign rd_data_o[k*DATA_W +: DATA_W] = !live                           ? '0 :
                                           (wr_en_i && (wr_addr_i == ra)) ? wr_data_i :
                                                                            mem_q[ra];
`else
    assign rd_data_o[k*DATA_W +: DATA_W] = live ? mem_q[ra] : '0;
`endif
  end

endmodule

// File: tb/tb_regs_file_mp.sv
// Directed self-checking bench for regs_file_mp (default parameters).
module tb_regs_file_mp;
  import regs_file_mp_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NRD = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              clr_req;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regs_file_mp_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_if ();

  regs_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .NRD(NRD), .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .clr_req_i(clr_req),
    .busy_o   (busy),
    .dbg      (dbg_if)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset;
    int n;
    wr_en = 0; wr_addr = '0; wr_data = '0; clr_req = 0;
    dbg_if.dbg_req_i = 0; dbg_if.dbg_we_i = 0; dbg_if.dbg_addr_i = '0; dbg_if.dbg_wdata_i = '0;
    set_rd(5'd5, 5'd6);
    #2 rst_n = 0;
    #10;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (dbg_if.dbg_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", dbg_if.dbg_ack_o); end
    checks++; if (dbg_if.dbg_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", dbg_if.dbg_rdata_o); end
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    tick;
    rst_n = 1;
    n = 0;
    while (busy && n < 40) begin tick; n++; end
    checks++; if (n !== 32) begin failures++; $display("FAIL reset_busy_cycles got=%0d exp=32", n); end
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), AW'(31 - a));
      #1;
      checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL swept_zero a=%0d got=%h exp=0", a, rd_data); end
    end
  endtask

  task automatic test_core_write;
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick;
    wr_en = 0; set_rd(5'd5, 5'd0); #1;
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_x5 got=%h exp=deadbeef", rd_data[31:0]); end
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'h1;
    tick;
    wr_en = 0; set_rd(5'd0, 5'd0); #1;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL wr_x0 got=%h exp=0", rd_data); end
    wr_en = 1; wr_addr = 5'd31; wr_data = 32'hCAFEF00D;
    tick;
    wr_en = 0; set_rd(5'd0, 5'd31); #1;
    checks++; if (rd_data[63:32] !== 32'hCAFEF00D) begin failures++; $display("FAIL wr_x31 got=%h exp=cafef00d", rd_data[63:32]); end
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'h1234; set_rd(5'd0, 5'd5); #1;
`ifdef REGS_FILE_BYPASS_EN
    checks++; if (rd_data[63:32] !== 32'h1234) begin failures++; $display("FAIL bypass got=%h exp=1234", rd_data[63:32]); end
`else
    checks++; if (rd_data[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL no_bypass got=%h exp=deadbeef", rd_data[63:32]); end
`endif
    tick;
    wr_en = 0; #1;
    checks++; if (rd_data[63:32] !== 32'h1234) begin failures++; $display("FAIL wr_x5_after got=%h exp=1234", rd_data[63:32]); end
  endtask

  task automatic test_debug;
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'h33;
    dbg_if.dbg_req_i = 1; dbg_if.dbg_we_i = 1; dbg_if.dbg_addr_i = 5'd7; dbg_if.dbg_wdata_i = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (dbg_if.dbg_ack_o !== 1'b0) begin failures++; $display("FAIL dbg_stall i=%0d got=%b exp=0", i, dbg_if.dbg_ack_o); end
    end
    wr_en = 0;
    tick;
    checks++; if (dbg_if.dbg_ack_o !== 1'b1) begin failures++; $display("FAIL dbg_wr_ack got=%b exp=1", dbg_if.dbg_ack_o); end
    dbg_if.dbg_req_i = 0;
    tick;
    checks++; if (dbg_if.dbg_ack_o !== 1'b0) begin failures++; $display("FAIL dbg_ack_pulse got=%b exp=0", dbg_if.dbg_ack_o); end
    set_rd(5'd7, 5'd3); #1;
    checks++; if (rd_data !== {32'h33, 32'hA5A5A5A5}) begin failures++; $display("FAIL dbg_wr_data got=%h exp=00000033a5a5a5a5", rd_data); end
    dbg_if.dbg_req_i = 1; dbg_if.dbg_we_i = 0; dbg_if.dbg_addr_i = 5'd7;
    tick;
    checks++; if (dbg_if.dbg_ack_o !== 1'b1 || dbg_if.dbg_rdata_o !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL dbg_rd ack=%b rdata=%h exp ack=1 rdata=a5a5a5a5", dbg_if.dbg_ack_o, dbg_if.dbg_rdata_o); end
    dbg_if.dbg_req_i = 0;
    tick;
    checks++; if (dbg_if.dbg_ack_o !== 1'b0 || dbg_if.dbg_rdata_o !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL dbg_rd_hold ack=%b rdata=%h exp ack=0 rdata=a5a5a5a5", dbg_if.dbg_ack_o, dbg_if.dbg_rdata_o); end
    // Debug read racing a core write to the same entry sees the old value.
    dbg_if.dbg_req_i = 1; dbg_if.dbg_addr_i = 5'd3;
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'h99;
    tick;
    checks++; if (dbg_if.dbg_ack_o !== 1'b1 || dbg_if.dbg_rdata_o !== 32'h33) begin
      failures++; $display("FAIL dbg_rd_old ack=%b rdata=%h exp ack=1 rdata=33", dbg_if.dbg_ack_o, dbg_if.dbg_rdata_o); end
    dbg_if.dbg_req_i = 0; wr_en = 0;
    tick;
    set_rd(5'd3, 5'd0); #1;
    checks++; if (rd_data[31:0] !== 32'h99) begin failures++; $display("FAIL core_wr_x3 got=%h exp=99", rd_data[31:0]); end
    dbg_if.dbg_req_i = 1; dbg_if.dbg_we_i = 1; dbg_if.dbg_addr_i = 5'd0; dbg_if.dbg_wdata_i = 32'hFFFF;
    tick;
    dbg_if.dbg_req_i = 0;
    tick;
    dbg_if.dbg_req_i = 1; dbg_if.dbg_we_i = 0;
    tick;
    checks++; if (dbg_if.dbg_ack_o !== 1'b1 || dbg_if.dbg_rdata_o !== 32'h0) begin
      failures++; $display("FAIL dbg_x0 ack=%b rdata=%h exp ack=1 rdata=0", dbg_if.dbg_ack_o, dbg_if.dbg_rdata_o); end
    dbg_if.dbg_req_i = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic exp_ack [4];
    int   acks;
    exp_ack[0] = 1; exp_ack[1] = 0; exp_ack[2] = 1; exp_ack[3] = 0;
    acks = 0;
    dbg_if.dbg_req_i = 1; dbg_if.dbg_we_i = 1; dbg_if.dbg_addr_i = 5'd8; dbg_if.dbg_wdata_i = 32'h11;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (dbg_if.dbg_ack_o === 1'b1) acks++;
      checks++; if (dbg_if.dbg_ack_o !== exp_ack[i]) begin failures++; $display("FAIL hold_ack i=%0d got=%b exp=%b", i, dbg_if.dbg_ack_o, exp_ack[i]); end
    end
    dbg_if.dbg_req_i = 0;
    checks++; if (acks !== 2) begin failures++; $display("FAIL hold_ack_count got=%0d exp=2", acks); end
    checks++; if (dbg_if.dbg_rdata_o !== 32'h11) begin failures++; $display("FAIL hold_rdata got=%h exp=11", dbg_if.dbg_rdata_o); end
    tick;
    set_rd(5'd8, 5'd0); #1;
    checks++; if (rd_data[31:0] !== 32'h11) begin failures++; $display("FAIL hold_x8 got=%h exp=11", rd_data[31:0]); end
  endtask

  task automatic test_clear;
    int n;
    wr_en = 1; wr_addr = 5'd9; wr_data = 32'h55;
    tick;
    wr_en = 0; set_rd(5'd9, 5'd4); #1;
    checks++; if (rd_data[31:0] !== 32'h55) begin failures++; $display("FAIL clr_pre_x9 got=%h exp=55", rd_data[31:0]); end
    clr_req = 1;
    tick;
    clr_req = 0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 5) begin
        wr_en = 1; wr_addr = 5'd4; wr_data = 32'h44; #1;
        checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL clr_busy_read got=%h exp=0", rd_data); end
      end else begin
        wr_en = 0;
      end
      tick;
    end
    wr_en = 0;
    checks++; if (n !== 32) begin failures++; $display("FAIL clr_busy_cycles got=%0d exp=32", n); end
    #1;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL clr_after got=%h exp=0", rd_data); end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    clr_req = 1;
    dbg_if.dbg_req_i = 1; dbg_if.dbg_we_i = 0; dbg_if.dbg_addr_i = 5'd2;
    tick;
    clr_req = 0;
    checks++; if (busy !== 1'b1 || dbg_if.dbg_ack_o !== 1'b0) begin
      failures++; $display("FAIL mid_start busy=%b ack=%b exp busy=1 ack=0", busy, dbg_if.dbg_ack_o); end
    for (int i = 0; i < 10; i++) tick;
    rst_n = 0; #1;
    checks++; if (busy !== 1'b1 || dbg_if.dbg_ack_o !== 1'b0 || dbg_if.dbg_rdata_o !== 32'h0) begin
      failures++; $display("FAIL mid_reset busy=%b ack=%b rdata=%h exp 1 0 0", busy, dbg_if.dbg_ack_o, dbg_if.dbg_rdata_o); end
    tick;
    tick;
    rst_n = 1;
    n = 0;
    while (busy && n < 40) begin
      tick; n++;
      if (busy && dbg_if.dbg_ack_o !== 1'b0) begin failures++; checks++; $display("FAIL mid_ack_busy n=%0d got=1 exp=0", n); end
    end
    checks++; if (n !== 32) begin failures++; $display("FAIL mid_busy_cycles got=%0d exp=32", n); end
    checks++; if (dbg_if.dbg_ack_o !== 1'b0) begin failures++; $display("FAIL mid_ack_idle got=%b exp=0", dbg_if.dbg_ack_o); end
    tick;
    checks++; if (dbg_if.dbg_ack_o !== 1'b1) begin failures++; $display("FAIL mid_pending_ack got=%b exp=1", dbg_if.dbg_ack_o); end
    dbg_if.dbg_req_i = 0;
    tick;
    checks++; if (dbg_if.dbg_ack_o !== 1'b0) begin failures++; $display("FAIL mid_ack_end got=%b exp=0", dbg_if.dbg_ack_o); end
  endtask

  initial begin
    test_reset;
    test_core_write;
    test_debug;
    test_back_to_back;
    test_clear;
    test_reset_mid_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
